stream_coord_tracker: RTL
=========================

STREAM_COORD_TRACKER -- requirements
Module: stream_coord_tracker

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 640: pixels per line.
REQ-002 SHALL have parameter ROW_NUMBER, default 480: lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 24: pixel data bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sink_valid  in  1  input pixel valid.
- sink_ready  out  1  input pixel accepted when high with sink_valid.
- sink_data  in  DATA_WIDTH  input pixel.
- sink_sop  in  1  first pixel of frame.
- sink_eop  in  1  last pixel of frame.
- source_valid  out  1  output pixel valid.
- source_ready  in  1  downstream accepts.
- source_data  out  DATA_WIDTH  forwarded pixel.
- source_x  out  16  column of forwarded pixel.
- source_y  out  16  row of forwarded pixel.
- source_sop  out  1  forwarded sop.
- source_eop  out  1  forwarded eop.
- err_short  out  1  one-cycle pulse on early frame end.
- err_long  out  1  one-cycle pulse on missing eop.

Function
REQ-006 SHALL define input accept as sink_valid && sink_ready, and output transfer as source_valid && source_ready.
REQ-007 SHALL hold one output register stage: sink_ready = !source_valid || source_ready (combinational); latency 1 cycle from accept to source_valid.
REQ-008 SHALL keep source_* stable while source_valid && !source_ready.
REQ-009 SHALL use states IDLE and ACTIVE; in IDLE, accepted pixels without sink_sop SHALL be consumed and not forwarded.
REQ-010 SHALL, on an accepted sink_sop (either state), forward the pixel with x=0, y=0 and enter ACTIVE.
REQ-011 SHALL, in ACTIVE, tag each accepted non-sop pixel with the next raster position: x+1, or x=0 and y+1 when x == LINE_WIDTH-1.
REQ-012 SHALL return to IDLE after an accepted pixel with sink_eop.
REQ-013 SHALL return to IDLE after forwarding the pixel at (LINE_WIDTH-1, ROW_NUMBER-1), whether or not it carried eop.
REQ-014 SHALL hold counters when no accept occurs; counter arithmetic 16-bit unsigned, parameters SHALL NOT exceed 65535.
REQ-015 SHALL forward sink_sop/sink_eop unchanged with the pixel.

Reset
REQ-016 SHALL, on rst, set state IDLE, source_valid=0, source_x=0, source_y=0, source_sop=0, source_eop=0, source_data=0, err_short=0, err_long=0; discard any held pixel.
REQ-017 SHALL take reset priority over all other events including a same-cycle accept.

Configuration
REQ-018 SHALL gate geometry checking with macro STREAM_COORD_FRAME_ERR_EN.
REQ-019 With macro: err_short SHALL pulse in the accept cycle of eop at a position before (LINE_WIDTH-1, ROW_NUMBER-1), or of sop while ACTIVE; err_long SHALL pulse in the accept cycle of the last-position pixel lacking eop.
REQ-020 Without macro: err_short and err_long SHALL be constant 0; forwarding and state behaviour unchanged.

Structure
REQ-021 SHALL place state enum (IDLE, ACTIVE) and coordinate width constant (16) in package stream_coord_pkg.
REQ-022 SHALL implement the valid/ready output register as sub-module st_pipe_reg; FSM and counters stay in stream_coord_tracker.

Verification (LINE_WIDTH=4, ROW_NUMBER=3)
REQ-023 Full frame of 12 pixels, sop first, eop last, source_ready=1 -> x/y run (0,0)..(3,0),(0,1)..(3,2); no error pulses; IDLE after.
REQ-024 Three pixels without sop, then a frame -> first three not forwarded; frame forwarded from (0,0).
REQ-025 source_ready=0 for 5 cycles at pixel (2,1) -> sink_ready=0, source_* held at (2,1); resumes with (3,1), no pixel lost or duplicated.
REQ-026 eop on 6th pixel (1,1) -> err_short pulse (macro on), IDLE; macro off -> err_short stays 0.
REQ-027 12th pixel without eop -> err_long pulse (macro on); next non-sop pixel dropped.
REQ-028 rst asserted while pixel (1,2) is held -> next cycle source_valid=0, x=y=0, IDLE.

Source files
------------

// File: rtl/stream_coord_tracker_pkg.sv
// Shared types and constants for the stream coordinate tracker.
package stream_coord_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int unsigned COORD_W = 16;

endpackage

// File: rtl/stream_coord_tracker_if.sv
// Pixel stream bundle: valid/ready handshake plus data, raster tag and framing.
interface stream_coord_tracker_if
  import stream_coord_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [COORD_W-1:0]    x;
  logic [COORD_W-1:0]    y;
  logic                  sop;
  logic                  eop;

  modport master (output valid, data, x, y, sop, eop, input ready);
  modport slave  (input valid, data, x, y, sop, eop, output ready);
endinterface

// File: rtl/stream_coord_tracker_pipe.sv
// Single-entry valid/ready output register; holds its payload while stalled.
module st_pipe_reg
  import stream_coord_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24
) (
  input logic                     clk,
  input logic                     rst,
  stream_coord_tracker_if.slave   sink_if,
  stream_coord_tracker_if.master  source_if
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [COORD_W-1:0]    x_q;
  logic [COORD_W-1:0]    y_q;
  logic                  sop_q;
  logic                  eop_q;

  // Accepting is allowed whenever the slot is empty or being drained this cycle.
  assign sink_if.ready = !valid_q || source_if.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (sink_if.ready) begin
      valid_q <= sink_if.valid;
      if (sink_if.valid) begin
        data_q <= sink_if.data;
        x_q    <= sink_if.x;
        y_q    <= sink_if.y;
        sop_q  <= sink_if.sop;
        eop_q  <= sink_if.eop;
      end
    end
  end

  assign source_if.valid = valid_q;
  assign source_if.data  = data_q;
  assign source_if.x     = x_q;
  assign source_if.y     = y_q;
  assign source_if.sop   = sop_q;
  assign source_if.eop   = eop_q;
endmodule

// File: rtl/stream_coord_tracker.sv
// Tags each pixel of a framed stream with its raster (x,y) position.
// Frame geometry error pulses are built only with STREAM_COORD_FRAME_ERR_EN.
module stream_coord_tracker
  import stream_coord_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned ROW_NUMBER = 480,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic [COORD_W-1:0]    source_x,
  output logic [COORD_W-1:0]    source_y,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic                  err_short,
  output logic                  err_long
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(LINE_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUMBER - 1);

  stream_coord_tracker_if #(.DATA_WIDTH(DATA_WIDTH)) pipe_in  ();
  stream_coord_tracker_if #(.DATA_WIDTH(DATA_WIDTH)) pipe_out ();

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               accept;
  logic               fwd;
  logic               last;

  assign sink_ready = pipe_in.ready;
  assign accept     = sink_valid && sink_ready;

  // x_q/y_q hold the position of the most recently forwarded pixel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fwd     = 1'b0;
    last    = 1'b0;
    if (accept) begin
      if (sink_sop) begin
        fwd = 1'b1;
        x_d = '0;
        y_d = '0;
      end else if (state_q == ACTIVE) begin
        fwd = 1'b1;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      last = (x_d == X_LAST) && (y_d == Y_LAST);
      if (fwd) begin
        state_d = (sink_eop || last) ? IDLE : ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign pipe_in.valid = fwd;
  assign pipe_in.data  = sink_data;
  assign pipe_in.x     = x_d;
  assign pipe_in.y     = y_d;
  assign pipe_in.sop   = sink_sop;
  assign pipe_in.eop   = sink_eop;

  st_pipe_reg #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .sink_if   (pipe_in.slave),
    .source_if (pipe_out.master)
  );

  assign pipe_out.ready = source_ready;
  assign source_valid   = pipe_out.valid;
  assign source_data    = pipe_out.data;
  assign source_x       = pipe_out.x;
  assign source_y       = pipe_out.y;
  assign source_sop     = pipe_out.sop;
  assign source_eop     = pipe_out.eop;

`ifdef STREAM_COORD_FRAME_ERR_EN
  assign err_short = !rst && fwd && ((sink_sop && state_q == ACTIVE) || (sink_eop && !last));
  assign err_long  = !rst && fwd && last && !sink_eop;
`else
  assign err_short = 1'b0;
  assign err_long  = 1'b0;
`endif
endmodule
